// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module   : mem_access_unit
//  Brief    : MEM-stage load/store engine. Decodes the EX/MEM opcode, builds
//             byte enables and lane-replicated store data, checks alignment,
//             runs a valid/ack bus transaction with timeout and extends loads.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_valid,
    input  logic              flush,
    input  logic [31:0]       ir,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic              exc_valid,
    output logic [1:0]        exc_code,
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         exc_code_q, exc_code_d;
    logic [31:0]        ld_data_q, ld_data_d;

    logic [ADDR_W-1:0]  addr_q;
    logic [3:0]         be_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic [1:0]         lane_q;
    logic [1:0]         size_q;
    logic               signed_q;
    logic               load_q;

    logic               w_is_mem, w_is_load, w_is_signed;
    logic [1:0]         w_size;
    logic               w_misalign;
    logic [1:0]         w_lane;
    logic [3:0]         w_be;
    logic [31:0]        w_st_data;
    logic               w_start;
    logic               w_capture;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_ld_ext;
    logic               w_unused;

    // Only the opcode field of the instruction matters here
    assign w_unused = ^ir[25:0];

    // Opcode decode: memory-op flag, direction, access size and signedness
    always_comb begin
        w_is_mem    = 1'b1;
        w_is_load   = 1'b1;
        w_is_signed = 1'b0;
        w_size      = SZ_W;
        case (ir[31:26])
            6'b100011: begin end
            6'b100001: begin w_size = SZ_H; w_is_signed = 1'b1; end
            6'b100000: begin w_size = SZ_B; w_is_signed = 1'b1; end
            6'b100101: w_size = SZ_H;
            6'b100100: w_size = SZ_B;
            6'b101011: w_is_load = 1'b0;
            6'b101001: begin w_is_load = 1'b0; w_size = SZ_H; end
            6'b101000: begin w_is_load = 1'b0; w_size = SZ_B; end
            default:   begin w_is_mem = 1'b0; w_is_load = 1'b0; end
        endcase
    end

    // Alignment check and byte lane; with the check disabled wider ops use lane 0
    always_comb begin
        w_misalign = 1'b0;
        w_lane     = 2'b00;
        case (w_size)
            SZ_B: w_lane = addr[1:0];
            SZ_H: begin
                w_misalign = ALIGN_CHECK && addr[0];
                w_lane     = ALIGN_CHECK ? {addr[1], 1'b0} : 2'b00;
            end
            default: w_misalign = ALIGN_CHECK && (addr[1:0] != 2'b00);
        endcase
    end

    // Byte enables and lane-replicated store data (loads read the full word)
    always_comb begin
        w_be      = 4'hF;
        w_st_data = wdata;
        if (!w_is_load) begin
            case (w_size)
                SZ_B: begin
                    w_be      = 4'b0001 << w_lane;
                    w_st_data = {4{wdata[7:0]}};
                end
                SZ_H: begin
                    w_be      = w_lane[1] ? 4'b1100 : 4'b0011;
                    w_st_data = {2{wdata[15:0]}};
                end
                default: begin end
            endcase
        end
    end

    // Select the addressed byte/halfword of the read word and extend it
    always_comb begin
        case (lane_q)
            2'd0:    w_byte = bus_rdata[7:0];
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            SZ_B:    w_ld_ext = signed_q ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            SZ_H:    w_ld_ext = signed_q ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            default: w_ld_ext = bus_rdata;
        endcase
    end

    assign w_start = mem_valid && w_is_mem && !flush;

    // Next-state logic: accept/reject in IDLE, ack or timeout in REQ
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        exc_code_d = exc_code_q;
        ld_data_d  = ld_data_q;
        w_capture  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    if (w_misalign) begin
                        exc_code_d = w_is_load ? 2'b01 : 2'b10;
                        state_d    = S_ERR;
                    end else begin
                        w_capture  = 1'b1;
                        exc_code_d = 2'b00;
                        cnt_d      = '0;
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    if (load_q) begin
                        ld_data_d = w_ld_ext;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == TO_LAST) begin
                        exc_code_d = 2'b11;
                        state_d    = S_ERR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            exc_code_q <= 2'b00;
            ld_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            exc_code_q <= exc_code_d;
            ld_data_q  <= ld_data_d;
        end
    end

    // Transaction attributes latched on acceptance; held stable through REQ
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            be_q     <= 4'd0;
            we_q     <= 1'b0;
            wdata_q  <= 32'd0;
            lane_q   <= 2'd0;
            size_q   <= SZ_B;
            signed_q <= 1'b0;
            load_q   <= 1'b0;
        end else if (w_capture) begin
            addr_q   <= {addr[ADDR_W-1:2], 2'b00};
            be_q     <= w_be;
            we_q     <= !w_is_load;
            wdata_q  <= w_st_data;
            lane_q   <= w_lane;
            size_q   <= w_size;
            signed_q <= w_is_signed;
            load_q   <= w_is_load;
        end
    end

    // Stall is forced low while reset is asserted so the pipeline is released at once
    assign stall     = reset_n && (((state_q == S_IDLE) && w_start) || (state_q == S_REQ));
    assign bus_req   = (state_q == S_REQ);
    assign ld_valid  = (state_q == S_DONE) && load_q;
    assign exc_valid = (state_q == S_ERR);
    assign exc_code  = exc_code_q;
    assign ld_data   = ld_data_q;
    assign bus_we    = we_q;
    assign bus_be    = be_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

`default_nettype wire
